// File: rtl/config_nios2_gen2_0_cpu_debug_cmd_seq.sv
// Debug command sequencer: decodes host debug commands and runs single
// OCI memory reads/writes with an ack timeout, reporting via MonDReg.
module config_nios2_gen2_0_cpu_debug_cmd_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [37:0] cmd_data,
    output logic        cmd_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [7:0]  addr_q
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_SETADDR = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    // Last WAIT count value; the next tick would reach TIMEOUT.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       op_write;
    logic [1:0] opcode;
    logic       unused_bits;

    assign opcode      = cmd_data[37:36];
    assign unused_bits = ^cmd_data[35:32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            op_write      <= 1'b0;
            cmd_busy      <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 8'd0;
            mem_wdata     <= 32'd0;
            MonDReg       <= 32'd0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            addr_q        <= 8'd0;
        end else begin
            mem_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        unique case (opcode)
                            OP_NOP: begin
                            end
                            OP_SETADDR: begin
                                addr_q        <= cmd_data[7:0];
                                monitor_ready <= 1'b1;
                                monitor_error <= 1'b0;
                            end
                            OP_WRITE, OP_READ: begin
                                // WRITE loads MonDReg on this edge, so the
                                // bus sees the new word directly.
                                if (opcode == OP_WRITE) begin
                                    MonDReg   <= cmd_data[31:0];
                                    mem_wdata <= cmd_data[31:0];
                                end else begin
                                    mem_wdata <= MonDReg;
                                end
                                op_write      <= (opcode == OP_WRITE);
                                mem_we        <= (opcode == OP_WRITE);
                                mem_addr      <= addr_q;
                                mem_req       <= 1'b1;
                                cmd_busy      <= 1'b1;
                                monitor_ready <= 1'b0;
                                monitor_error <= 1'b0;
                                state         <= ISSUE;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    cnt   <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!op_write) begin
                            MonDReg <= mem_rdata;
                        end
                        addr_q <= addr_q + 8'd1;
                        state  <= DONE;
                    end else if (cnt == LAST_CNT) begin
                        monitor_error <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    monitor_ready <= !monitor_error;
                    cmd_busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_nios2_gen2_0_cpu_debug_cmd_seq.sv
// Bench for the debug command sequencer: directed vector table, randomized
// transactions against a transaction-level model, and reset corner cases.
module tb_config_nios2_gen2_0_cpu_debug_cmd_seq;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [37:0] cmd_data = '0;
    logic        cmd_busy;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  addr_q;

    config_nios2_gen2_0_cpu_debug_cmd_seq #(.TIMEOUT(T)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_busy(cmd_busy),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .MonDReg(MonDReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error),
        .addr_q(addr_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] rdata;
        int          d;
        bit          junk;
        logic [7:0]  ra;
        logic [31:0] wd;
        logic [7:0]  ea;
        logic [31:0] em;
        bit          er;
        bit          ee;
        int          ec;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_addr;
    logic [31:0] m_mon;
    bit          m_rdy;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(cmd_busy), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_maddr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_mon"}, MonDReg, 0);
        chk({tag, "_rdy"}, 32'(monitor_ready), 0);
        chk({tag, "_err"}, 32'(monitor_error), 0);
        chk({tag, "_addr"}, 32'(addr_q), 0);
    endtask

    // One command from an idle negedge; d = WAIT cycle carrying ack (0 = none).
    task automatic run_cmd(input vec_t v, input string tag);
        int   done = -1;
        int   nreq = 0;
        int   back2back = 0;
        bit   prev = 0;
        logic [7:0]  ga = '0;
        logic        gwe = '0;
        logic [31:0] gwd = '0;
        @(negedge clk);
        chk({tag, "_idle_before"}, 32'(cmd_busy), 0);
        cmd_valid = 1'b1;
        cmd_data  = {v.op, 4'($urandom()), v.data};
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_data  = 38'({$urandom(), $urandom()});
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (mem_req) begin
                if (prev) back2back++;
                nreq++;
                ga  = mem_addr;
                gwe = mem_we;
                gwd = mem_wdata;
            end
            prev = mem_req;
            if (!cmd_busy) begin
                done = c;
                break;
            end
            if (v.d >= 1 && c == 1 + v.d) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
            if (c == 1 && $urandom_range(1) == 1) mem_ack = 1'b1;
            if (v.junk && $urandom_range(2) == 0) cmd_valid = 1'b1;
        end
        cmd_valid = 1'b0;
        mem_ack   = 1'b0;
        chk({tag, "_cycles"}, 32'(done), 32'(v.ec));
        chk({tag, "_nreq"}, 32'(nreq), (v.op[1] ? 1 : 0));
        chk({tag, "_b2b"}, 32'(back2back), 0);
        if (v.op[1]) begin
            chk({tag, "_req_addr"}, 32'(ga), 32'(v.ra));
            chk({tag, "_req_we"}, 32'(gwe), 32'(v.op == 2'b10));
            chk({tag, "_req_wdata"}, gwd, v.wd);
        end
        chk({tag, "_addr"}, 32'(addr_q), 32'(v.ea));
        chk({tag, "_mon"}, MonDReg, v.em);
        chk({tag, "_rdy"}, 32'(monitor_ready), 32'(v.er));
        chk({tag, "_err"}, 32'(monitor_error), 32'(v.ee));
    endtask

    vec_t vt[11];

    initial begin
        vt[0]  = '{2'b00, 32'h55, 0, 0, 0, 8'h00, 0, 8'h00, 32'h0, 0, 0, 1};
        vt[1]  = '{2'b01, 32'h10, 0, 0, 0, 8'h00, 0, 8'h10, 32'h0, 1, 0, 1};
        vt[2]  = '{2'b10, 32'hDEADBEEF, 0, 2, 0, 8'h10, 32'hDEADBEEF,
                   8'h11, 32'hDEADBEEF, 1, 0, 5};
        vt[3]  = '{2'b01, 32'h10, 0, 0, 0, 8'h00, 0, 8'h10, 32'hDEADBEEF,
                   1, 0, 1};
        vt[4]  = '{2'b11, 32'h0, 32'h12345678, 1, 0, 8'h10, 32'hDEADBEEF,
                   8'h11, 32'h12345678, 1, 0, 4};
        vt[5]  = '{2'b11, 32'h0, 32'h0, 0, 0, 8'h11, 32'h12345678,
                   8'h11, 32'h12345678, 0, 1, T + 3};
        vt[6]  = '{2'b00, 32'hFF, 0, 0, 0, 8'h00, 0, 8'h11, 32'h12345678,
                   0, 1, 1};
        vt[7]  = '{2'b01, 32'hFF, 0, 0, 0, 8'h00, 0, 8'hFF, 32'h12345678,
                   1, 0, 1};
        vt[8]  = '{2'b10, 32'hCAFEF00D, 0, 3, 1, 8'hFF, 32'hCAFEF00D,
                   8'h00, 32'hCAFEF00D, 1, 0, 6};
        vt[9]  = '{2'b11, 32'h0, 32'hAABBCCDD, T, 0, 8'h00, 32'hCAFEF00D,
                   8'h01, 32'hAABBCCDD, 1, 0, T + 3};
        vt[10] = '{2'b10, 32'h0BADF00D, 32'h0, T + 1, 0, 8'h01, 32'h0BADF00D,
                   8'h01, 32'h0BADF00D, 0, 1, T + 3};

        #2;
        check_zero("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("reset_release");

        for (int i = 0; i < 11; i++) begin
            run_cmd(vt[i], $sformatf("vec%0d", i));
        end

        m_addr = 8'h01;
        m_mon  = 32'h0BADF00D;
        m_rdy  = 0;
        m_err  = 1;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            bit   acked;
            v.op    = 2'($urandom_range(3));
            v.data  = $urandom();
            v.rdata = $urandom();
            v.d     = $urandom_range(T + 1);
            v.junk  = 1'($urandom_range(1));
            v.ra    = m_addr;
            v.wd    = (v.op == 2'b10) ? v.data : m_mon;
            v.ec    = 1;
            case (v.op)
                2'b01: begin
                    m_addr = v.data[7:0];
                    m_rdy  = 1;
                    m_err  = 0;
                end
                2'b10, 2'b11: begin
                    acked = (v.d >= 1 && v.d <= T);
                    v.ec  = (acked ? v.d : T) + 3;
                    if (v.op == 2'b10) m_mon = v.data;
                    if (acked) begin
                        if (v.op == 2'b11) m_mon = v.rdata;
                        m_addr = m_addr + 8'd1;
                        m_rdy  = 1;
                        m_err  = 0;
                    end else begin
                        m_rdy = 0;
                        m_err = 1;
                    end
                end
                default: begin
                end
            endcase
            v.ea = m_addr;
            v.em = m_mon;
            v.er = m_rdy;
            v.ee = m_err;
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        // Reset during WAIT, then a late ack must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = {2'b11, 36'h0};
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("midwait_busy", 32'(cmd_busy), 1);
        #2 reset = 1'b1;
        #1;
        check_zero("midwait_reset");
        @(negedge clk);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h99887766;
        @(negedge clk);
        mem_ack = 1'b0;
        check_zero("late_ack");
        @(negedge clk);
        check_zero("late_ack_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/config_nios2_gen2_0_cpu_debug_cmd_seq.md
CONFIG_NIOS2_GEN2_0_CPU_DEBUG_CMD_SEQ -- requirements
Module: config_nios2_gen2_0_cpu_debug_cmd_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 SHALL provide parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for mem_ack (range 1..255).
REQ-003 SHALL provide the following ports, one per line: name, direction, width, meaning.
  clk  in  1  system clock; all logic on its rising edge
  reset  in  1  async active-high reset
  cmd_valid  in  1  one-cycle strobe; cmd_data holds a decoded debug command
  cmd_data  in  38  [37:36] opcode, [35:32] unused, [31:0] payload
  cmd_busy  out  1  command in progress; new cmd_valid ignored
  mem_req  out  1  OCI memory access request
  mem_we  out  1  1 = write, 0 = read; valid while mem_req
  mem_addr  out  8  word address; valid while mem_req
  mem_wdata  out  32  write data; valid while mem_req
  mem_ack  in  1  one-cycle completion strobe from memory
  mem_rdata  in  32  read data; valid with mem_ack
  MonDReg  out  32  monitor data register (last read or written word)
  monitor_ready  out  1  last command completed without error
  monitor_error  out  1  last command timed out
  addr_q  out  8  current address pointer

Function
REQ-004 SHALL decode opcodes: 00 NOP, 01 SETADDR, 10 WRITE, 11 READ.
REQ-005 SHALL implement states IDLE, ISSUE, WAIT, DONE; cmd_busy = 1 in every state except IDLE.
REQ-006 In IDLE, cmd_valid with NOP SHALL cause no state change and no output change.
REQ-007 In IDLE, cmd_valid with SETADDR SHALL load addr_q <= cmd_data[7:0] on the same edge, set monitor_ready = 1 and monitor_error = 0, and stay in IDLE.
REQ-008 In IDLE, cmd_valid with WRITE SHALL latch MonDReg <= cmd_data[31:0], clear monitor_ready and monitor_error, and go to ISSUE.
REQ-009 In IDLE, cmd_valid with READ SHALL clear monitor_ready and monitor_error and go to ISSUE.
REQ-010 ISSUE SHALL last one cycle, with mem_req = 1, mem_addr = addr_q, mem_we = (opcode == WRITE), and mem_wdata = MonDReg; it then goes to WAIT.
REQ-011 In WAIT, mem_req SHALL deassert, and an 8-bit timeout counter SHALL start at 0 and increment once per cycle.
REQ-012 In WAIT, mem_ack SHALL cause the following, then go to DONE:
  READ: MonDReg <= mem_rdata.
  Both opcodes: addr_q <= addr_q + 1, modulo 256 (0xFF wraps to 0x00).
REQ-013 In WAIT, if the counter reaches TIMEOUT without mem_ack, the block SHALL set monitor_error = 1 and go to DONE; addr_q and MonDReg SHALL be left unchanged.
REQ-014 If mem_ack arrives on the same cycle the counter reaches TIMEOUT, ack SHALL win: no error is flagged.
REQ-015 DONE SHALL last one cycle, set monitor_ready = !monitor_error, and return to IDLE.
REQ-016 Best-case latency, from cmd_valid to monitor_ready = 1, SHALL be 4 cycles when mem_ack arrives in the first WAIT cycle.
REQ-017 cmd_valid asserted while cmd_busy = 1 SHALL be dropped with no side effects.
REQ-018 mem_ack received outside WAIT SHALL be ignored.
REQ-019 mem_req SHALL never be asserted for two consecutive cycles.
REQ-020 An opcode latched at cmd_valid SHALL be held internally until DONE; cmd_data is not required to be stable after the strobe.

Reset
REQ-021 Asserting reset SHALL immediately force:
  state = IDLE
  MonDReg = 0, addr_q = 0
  mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  monitor_ready = 0, monitor_error = 0
  cmd_busy = 0, timeout counter = 0
REQ-022 Reset asserted mid-transaction SHALL abort the transaction; a mem_ack arriving after reset release SHALL be ignored.

Verification
REQ-023 SETADDR 0x10, then WRITE 0xDEADBEEF, with ack after 2 cycles -> one mem_req with we = 1, addr = 0x10, wdata = 0xDEADBEEF; then addr_q = 0x11, monitor_ready = 1.
REQ-024 SETADDR 0x10, then READ, with mem_rdata = 0x12345678 and ack in the first WAIT cycle -> MonDReg = 0x12345678, addr_q = 0x11, monitor_ready high 4 cycles after cmd_valid.
REQ-025 READ with no ack and TIMEOUT = 8 -> monitor_error = 1, monitor_ready = 0, addr_q unchanged, return to IDLE after 8 WAIT cycles plus DONE.
REQ-026 SETADDR 0xFF, then WRITE with ack -> addr_q wraps to 0x00; a second cmd_valid pulsed during WAIT produces no extra mem_req.
REQ-027 Reset asserted during WAIT, then a late mem_ack -> all outputs equal reset values; MonDReg stays 0.
REQ-028 mem_ack on the exact cycle the counter reaches TIMEOUT -> monitor_ready = 1, monitor_error = 0.
